// File: rtl/ysyx_23060096_ifu.sv
// ysyx_23060096_ifu -- instruction fetch unit
//
// Owns the architectural PC and fetches one 32-bit word at a time from
// instruction memory. Each fetch moves through a short FSM:
// request, wait for data, hold the word for decode. When decode consumes
// the word, the PC advances to pc+4 or to a redirect target from execute.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   clk             core clock, rising-edge active
//   rst             asynchronous active-high reset
//   req_valid       fetch request to instruction memory (state REQ)
//   req_ready       memory accepts the request this cycle
//   req_addr        fetch address (always equals pc)
//   rsp_valid       instruction word returned this cycle (sampled only in WAIT)
//   rsp_data        returned instruction word
//   inst_valid      inst holds a valid instruction (state HOLD)
//   inst_ready      decode consumes inst this cycle
//   inst            captured instruction word
//   pc              address of the instruction being fetched or held
//   redirect_valid  use redirect_pc instead of pc+4 (sampled on handshake)
//   redirect_pc     redirect target
//   fetch_cnt       number of completed decode handshakes (wraps)
//   fault           misaligned fetch target trap (state FAULT)
//
// Configuration macro:
//   YSYX_23060096_IFU_MISALIGN_EN
//     defined:   a misaligned next PC is loaded as-is and the unit parks
//                in FAULT until reset.
//     undefined: the next PC has bits [1:0] cleared, there is no FAULT
//                state and fault is tied low.

module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt,
    output logic        fault
);

`ifdef YSYX_23060096_IFU_MISALIGN_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] inst_q;
    logic [31:0] inst_next;
    logic [31:0] cnt_q;
    logic [31:0] cnt_next;

    logic        handshake;
    logic [31:0] target;

    // Decode has taken the held word this cycle.
    assign handshake = (state == HOLD) && inst_ready;

    // Next fetch address chosen at handshake time; pc+4 wraps naturally.
    assign target = redirect_valid ? redirect_pc : (pc_q + 32'd4);

    // State and datapath registers; everything is reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            inst_q <= 32'h0;
            cnt_q  <= 32'h0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            inst_q <= inst_next;
            cnt_q  <= cnt_next;
        end
    end

    // Next-state and datapath update logic. rsp_valid only matters in WAIT,
    // so a stale response after an aborted transaction is dropped.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        inst_next  = inst_q;
        cnt_next   = cnt_q;

        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    inst_next  = rsp_data;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    cnt_next = cnt_q + 32'd1;
`ifdef YSYX_23060096_IFU_MISALIGN_EN
                    // Keep the offending target visible in pc for the trap.
                    pc_next = target;
                    if (target[1:0] != 2'b00) begin
                        state_next = FAULT;
                    end else begin
                        state_next = REQ;
                    end
`else
                    // Word fetches only: silently drop the low address bits.
                    pc_next    = target & 32'hFFFF_FFFC;
                    state_next = REQ;
`endif
                end
            end
`ifdef YSYX_23060096_IFU_MISALIGN_EN
            FAULT: begin
                state_next = FAULT;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs come straight from registers; no input reaches an output
    // combinationally.
    assign req_valid  = (state == REQ);
    assign inst_valid = (state == HOLD);
    assign req_addr   = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign fetch_cnt  = cnt_q;

`ifdef YSYX_23060096_IFU_MISALIGN_EN
    assign fault = (state == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// tb_ysyx_23060096_ifu -- directed self-checking bench for ysyx_23060096_ifu
//
// Two instances share every input: dut uses the default reset PC, dut_wrap
// starts at 32'hFFFF_FFFC so the pc+4 wrap can be observed alongside the
// normal sequence. Inputs change and outputs are sampled on the falling edge.

module tb_ysyx_23060096_ifu;

    logic        clk;
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;
    logic        fault;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [31:0] w_fetch_cnt;
    logic        w_fault;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    ysyx_23060096_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt),
        .fault          (fault)
    );

    ysyx_23060096_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (w_req_valid),
        .req_ready      (req_ready),
        .req_addr       (w_req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (inst_ready),
        .inst           (w_inst),
        .pc             (w_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (w_fetch_cnt),
        .fault          (w_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Put all inputs in their quiet state.
    task automatic clear_inputs();
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    // Reset and return at the falling edge of the first REQ cycle.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_pc  = 32'h8000_0000;
        exp_cnt = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        tests_run++;
        if (req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_valid: got %b expected 0", req_valid);
        end
        tests_run++;
        if (inst_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid);
        end
        tests_run++;
        if (fault !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fault: got %b expected 0", fault);
        end
        tests_run++;
        if (pc !== 32'h8000_0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: got %h expected 80000000", pc);
        end
        tests_run++;
        if (inst !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_inst: got %h expected 00000000", inst);
        end
        tests_run++;
        if (fetch_cnt !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fetch_cnt: got %h expected 00000000", fetch_cnt);
        end
        tests_run++;
        if (w_pc !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("[TB] FAIL reset_wrap_pc: got %h expected fffffffc", w_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        // One cycle in IDLE, no request yet.
        tests_run++;
        if (req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_req_valid: got %b expected 0", req_valid);
        end
        @(negedge clk);
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
            tests_failed++;
            $display("[TB] FAIL first_req: got valid=%b addr=%h expected valid=1 addr=80000000",
                     req_valid, req_addr);
        end
        exp_pc  = 32'h8000_0000;
        exp_cnt = 32'h0;
    endtask

    // Zero-wait memory, decode always ready, three fetches.
    task automatic test_sequential();
        logic [31:0] word;
        for (int i = 0; i < 3; i++) begin
            word = 32'h0000_0013 + (i * 32'h100);
            tests_run++;
            if (req_valid !== 1'b1 || req_addr !== exp_pc || inst_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL seq_req[%0d]: got valid=%b addr=%h ivalid=%b expected 1 %h 0",
                         i, req_valid, req_addr, inst_valid, exp_pc);
            end
            req_ready  = 1'b1;
            inst_ready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL seq_wait[%0d]: got req_valid=%b inst_valid=%b expected 0 0",
                         i, req_valid, inst_valid);
            end
            req_ready = 1'b0;
            rsp_valid = 1'b1;
            rsp_data  = word;
            @(negedge clk);
            tests_run++;
            if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc) begin
                tests_failed++;
                $display("[TB] FAIL seq_hold[%0d]: got ivalid=%b inst=%h pc=%h expected 1 %h %h",
                         i, inst_valid, inst, pc, word, exp_pc);
            end
            rsp_valid = 1'b0;
            @(negedge clk);
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            if (i == 0) begin
                tests_run++;
                if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_addr: got valid=%b addr=%h expected 1 00000000",
                             w_req_valid, w_req_addr);
                end
            end
        end
        inst_ready = 1'b0;
        tests_run++;
        if (fetch_cnt !== 32'd3 || req_addr !== 32'h8000_000C) begin
            tests_failed++;
            $display("[TB] FAIL seq_done: got cnt=%0d addr=%h expected 3 8000000c",
                     fetch_cnt, req_addr);
        end
    endtask

    task automatic test_backpressure();
        req_ready  = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (req_valid !== 1'b1 || req_addr !== exp_pc) begin
                tests_failed++;
                $display("[TB] FAIL req_stall[%0d]: got valid=%b addr=%h expected 1 %h",
                         i, req_valid, req_addr, exp_pc);
            end
            @(negedge clk);
        end
        tests_run++;
        if (req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL req_stall_end: got %b expected 1", req_valid);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hCAFE_0001;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001 || pc !== exp_pc
                || req_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin
                tests_failed++;
                $display("[TB] FAIL hold_stall[%0d]: got iv=%b inst=%h pc=%h rv=%b cnt=%0d expected 1 cafe0001 %h 0 %0d",
                         i, inst_valid, inst, pc, req_valid, fetch_cnt, exp_pc, exp_cnt);
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== exp_pc || fetch_cnt !== exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL hold_release: got rv=%b addr=%h cnt=%0d expected 1 %h %0d",
                     req_valid, req_addr, fetch_cnt, exp_pc, exp_cnt);
        end
    endtask

    task automatic test_redirect();
        // Redirect held through REQ and WAIT but dropped before the handshake.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        req_ready      = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0067;
        @(negedge clk);
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
        tests_run++;
        if (req_addr !== exp_pc) begin
            tests_failed++;
            $display("[TB] FAIL redirect_ignored: got %h expected %h", req_addr, exp_pc);
        end
        // Redirect presented on the handshake is taken.
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_006F;
        @(negedge clk);
        rsp_valid      = 1'b0;
        redirect_valid = 1'b1;
        inst_ready     = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        exp_pc  = 32'h8000_0100;
        exp_cnt = exp_cnt + 32'd1;
        tests_run++;
        if (req_valid !== 1'b1 || req_addr !== exp_pc || fetch_cnt !== exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL redirect_taken: got rv=%b addr=%h cnt=%0d expected 1 %h %0d",
                     req_valid, req_addr, fetch_cnt, exp_pc, exp_cnt);
        end
    endtask

    task automatic test_misalign();
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0073;
        @(negedge clk);
        rsp_valid      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        inst_ready     = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
`ifdef YSYX_23060096_IFU_MISALIGN_EN
        // Terminal: nothing the memory or decode side does moves it.
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (fault !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0
                || pc !== 32'h8000_0102 || fetch_cnt !== exp_cnt) begin
                tests_failed++;
                $display("[TB] FAIL misalign_fault[%0d]: got f=%b rv=%b iv=%b pc=%h cnt=%0d expected 1 0 0 80000102 %0d",
                         i, fault, req_valid, inst_valid, pc, fetch_cnt, exp_cnt);
            end
            @(negedge clk);
        end
`else
        tests_run++;
        if (fault !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_0100
            || fetch_cnt !== exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL misalign_align: got f=%b rv=%b addr=%h cnt=%0d expected 0 1 80000100 %0d",
                     fault, req_valid, req_addr, fetch_cnt, exp_cnt);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        // One complete fetch so that inst, pc and fetch_cnt are non-reset.
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        rsp_valid  = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        tests_run++;
        if (inst !== 32'hDEAD_BEEF || fetch_cnt !== 32'd1 || pc !== 32'h8000_0004) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset: got inst=%h cnt=%0d pc=%h expected deadbeef 1 80000004",
                     inst, fetch_cnt, pc);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        // Now in WAIT: abort with reset while a response arrives.
        rst       = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'h1234_5678;
        #1;
        tests_run++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0 || pc !== 32'h8000_0000
            || inst !== 32'h0 || fetch_cnt !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got rv=%b iv=%b f=%b pc=%h inst=%h cnt=%0d expected 0 0 0 80000000 0 0",
                     req_valid, inst_valid, fault, pc, inst, fetch_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_valid !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL stale_rsp_req: got rv=%b iv=%b inst=%h expected 1 0 00000000",
                     req_valid, inst_valid, inst);
        end
        @(negedge clk);
        tests_run++;
        if (req_valid !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL stale_rsp_hold: got rv=%b iv=%b inst=%h expected 1 0 00000000",
                     req_valid, inst_valid, inst);
        end
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_pc       = 32'h8000_0000;
        exp_cnt      = 32'h0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
